// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the RV32 IF stage: in-order fetch to a multi-cycle
// instruction memory, {pc, inst} buffering, and redirect flush with stale-response draining.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_inst,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state, state_nxt;
  entry_t [DEPTH-1:0]  q_mem;
  entry_t              head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, outstanding, stale, stale_base, stale_nxt;
  logic [CW:0]         credit_sum;
  logic [31:0]         fetch_pc, resp_pc;
  logic                credit_ok, issue, push, pop;

  // Credit covers both buffered and in-flight words so a response always has a slot.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok  = credit_sum < (CW+1)'(DEPTH);
  assign issue      = mem_req & mem_gnt;
  assign push       = (state == RUN) & ~redirect & mem_rvalid & (outstanding != '0);
  assign pop        = out_valid & out_ready & ~redirect;

  // Stale responses: in-flight requests orphaned by a redirect, minus one arriving now.
  always_comb begin
    stale_base = stale + outstanding;
    stale_nxt  = stale;
    if (redirect)
      stale_nxt = stale_base - CW'(mem_rvalid && (stale_base != '0));
    else if ((state == DRAIN) && mem_rvalid && (stale != '0))
      stale_nxt = stale - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (redirect && (stale_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (stale_nxt == '0)               state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_req  = ~rst & (state == RUN) & ~redirect & credit_ok;
    mem_addr = fetch_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      stale <= stale_nxt;
      if (redirect) begin
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        count       <= '0;
        outstanding <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        outstanding <= outstanding + CW'(issue) - CW'(push);
        count       <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset: outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {resp_pc, mem_rdata};
  end

  assign head      = q_mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc   : 32'h0;
  assign out_inst  = out_valid ? head.inst : 32'h0;
  assign level     = count;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst)
      assert (!(mem_rvalid && (outstanding == '0) && (stale == '0)))
        else $warning("if_prefetch_queue: mem_rvalid with no request pending, response ignored");
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a latency-programmable memory responder plus
// scenario tasks with hand-computed expectations (instruction word = pc + 0x1000_0000).
module tb_if_prefetch_queue;
  logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = 32'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  level;

  int errors = 0, checks = 0;
  int lat = 1, np = 0;
  bit mem_hold = 1'b0;
  logic [31:0] mq_addr[$], acc_addr[$];
  int          mq_due[$];
  logic [31:0] dummy_a;
  int          dummy_d;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .level(level)
  );

  // Memory responder: np indexes the upcoming rising edge; response due lat edges after accept.
  always begin
    @(negedge clk); #1;
    np++;
    if (!mem_hold && mq_due.size() > 0 && mq_due[0] <= np) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq_addr[0] + 32'h1000_0000;
      dummy_a = mq_addr.pop_front();
      dummy_d = mq_due.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    if (mem_req && mem_gnt) begin
      mq_addr.push_back(mem_addr);
      mq_due.push_back(np + lat);
      acc_addr.push_back(mem_addr);
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; out_ready = 1'b0; mem_gnt = 1'b0; mem_hold = 1'b0;
    mq_addr.delete(); mq_due.delete(); acc_addr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h500;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_pc, out_inst); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    redirect = 1'b0;
  endtask

  task automatic test_stream();
    reset_dut();
    lat = 1; mem_gnt = 1'b1; out_ready = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got %0b/%h want 1/00000000", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_fill: got out_valid %0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin errors++; $display("FAIL stream_first_out: got %0b %h %h want 1 00000000 10000000", out_valid, out_pc, out_inst); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || level !== 3'd1) begin
        errors++; $display("FAIL stream_seq%0d: got %0b %h lvl %0d want 1 %h lvl 1", k, out_valid, out_pc, level, 32'(4*k));
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    lat = 1; mem_gnt = 1'b1; out_ready = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", level); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stop: got %0b want 0", mem_req); end
    checks++; if (acc_addr.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", acc_addr.size()); end
    else begin
      checks++; if (acc_addr[3] !== 32'hC) begin errors++; $display("FAIL bp_last_addr: got %h want 0000000c", acc_addr[3]); end
    end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin errors++; $display("FAIL bp_head: got %h/%h want 00000000/10000000", out_pc, out_inst); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume: got %0b/%h want 1/00000010", mem_req, mem_addr); end
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL bp_pop: got %h want 00000004", out_pc); end
  endtask

  task automatic test_redirect_drain();
    reset_dut();
    lat = 3; mem_gnt = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_req_off: got %0b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL drain_mid: got req %0b lvl %0d want 0 0", mem_req, level); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || level !== 3'd0) begin errors++; $display("FAIL drain_exit: got %0b %h lvl %0d want 1 00000100 0", mem_req, mem_addr, level); end
    @(negedge clk);
    checks++; if (acc_addr.size() < 3 || acc_addr[2] !== 32'h100) begin errors++; $display("FAIL drain_next_req: got n=%0d want third request 00000100", acc_addr.size()); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_no_stale_out: got %0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h1000_0100) begin errors++; $display("FAIL drain_first_out: got %0b %h %h want 1 00000100 10000100", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_redirect_collision();
    reset_dut();
    lat = 1; mem_gnt = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL coll_setup_level: got %0d want 2", level); end
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL coll_flush: got %0b lvl %0d want 0 0", out_valid, level); end
    redirect = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL coll_restart: got %0b/%h want 1/00000200", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_dropped: got %0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h200 || out_inst !== 32'h1000_0200) begin errors++; $display("FAIL coll_first_out: got %h/%h want 00000200/10000200", out_pc, out_inst); end
  endtask

  task automatic test_reset_in_drain();
    reset_dut();
    lat = 3; mem_gnt = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0; mem_hold = 1'b1; rst = 1'b1;
    #2;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstdrain_mem: got %0b/%h want 0/00000000", mem_req, mem_addr); end
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_pc !== 32'h0) begin errors++; $display("FAIL rstdrain_out: got %0b lvl %0d pc %h want 0 0 0", out_valid, level, out_pc); end
    @(negedge clk);
    rst = 1'b0; mem_hold = 1'b0;
    #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstdrain_restart: got %0b/%h want 1/00000000", mem_req, mem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rstdrain_late_ignored: got %0b lvl %0d want 0 0", out_valid, level); end
    lat = 1; mem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin errors++; $display("FAIL rstdrain_first_out: got %0b %h %h want 1 00000000 10000000", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_pc_wrap();
    reset_dut();
    lat = 1; mem_gnt = 1'b0; out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %0b/%h want 1/fffffffc", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", mem_addr); end
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++; if (level !== 3'd2 || out_pc !== 32'hFFFF_FFFC || out_inst !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_head: got lvl %0d %h %h want 2 fffffffc 0ffffffc", level, out_pc, out_inst); end
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL wrap_fetch_pc: got %h want 00000004", mem_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (level !== 3'd1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin errors++; $display("FAIL wrap_second: got lvl %0d %h %h want 1 00000000 10000000", level, out_pc, out_inst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_reset_in_drain();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
